// File: rtl/mips_multicycle_core_if.sv
// Instruction-fetch and data-memory bus of the multi-cycle MIPS core.
// Latency: wires only; no storage in the interface.
// Backpressure: IR_valid stalls fetch, DM_ready stalls the data access.
interface mips_multicycle_core_if #(
    parameter int DMEM_AW = 7
);
    logic [31:0]        IR_addr;
    logic [31:0]        IR;
    logic               IR_valid;
    logic [31:0]        ReadDataMem;
    logic               DM_ready;
    logic               CEN;
    logic               WEN;
    logic               OEN;
    logic [DMEM_AW-1:0] A;
    logic [31:0]        Data2Mem;

    // Core side
    modport master (
        output IR_addr, CEN, WEN, OEN, A, Data2Mem,
        input  IR, IR_valid, ReadDataMem, DM_ready
    );

    // Memory side
    modport slave (
        input  IR_addr, CEN, WEN, OEN, A, Data2Mem,
        output IR, IR_valid, ReadDataMem, DM_ready
    );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB, one instruction in flight.
// Latency: 3 cycles for branches/jumps, 4 for ALU ops and sw, 5 for lw (zero wait states).
// Backpressure: holds in FETCH until IR_valid, holds in MEM with stable strobes until DM_ready.
module mips_multicycle_core #(
    parameter int          DMEM_AW  = 7,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_core_if.master  bus,
    output logic                    halted,
    output logic [CNT_W-1:0]        retired
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      npc_q, npc_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      rf_q [32];

    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;

    // Instruction fields, always taken from the latched instruction
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_f, rt_f, rd_f, shamt;
    logic [31:0] imm_sext, br_target, j_target, alu_res;
    logic        legal, br_taken, mem_active, is_sw;

    assign opcode    = ir_q[31:26];
    assign rs_f      = ir_q[25:21];
    assign rt_f      = ir_q[20:16];
    assign rd_f      = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign funct     = ir_q[5:0];
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign br_target = npc_q + {imm_sext[29:0], 2'b00};
    assign j_target  = {npc_q[31:28], ir_q[25:0], 2'b00};
    assign br_taken  = (rs_q == rt_q) ^ (opcode == OP_BNE);

    // Supported-instruction check; anything else traps to HALT from DECODE
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_JR, FN_ADD,
                    FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                       legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_LW, OP_SW:                 legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
    end

    // ALU on the operand registers; address/addi sum is the default
    always_comb begin
        alu_res = rs_q + imm_sext;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_res = rs_q + rt_q;
                FN_SUB:  alu_res = rs_q - rt_q;
                FN_AND:  alu_res = rs_q & rt_q;
                FN_OR:   alu_res = rs_q | rt_q;
                FN_SLT:  alu_res = {31'b0, ($signed(rs_q) < $signed(rt_q))};
                FN_SLL:  alu_res = rt_q << shamt;
                FN_SRL:  alu_res = rt_q >> shamt;
                default: alu_res = rs_q + rt_q;
            endcase
        end
    end

    // Next-state and datapath-register updates for the instruction FSM
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        npc_d     = npc_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_waddr  = rt_f;
        rf_wdata  = alu_q;

        case (state_q)
            S_FETCH: begin
                if (bus.IR_valid) begin
                    ir_d    = bus.IR;
                    npc_d   = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rs_d    = rf_q[rs_f];
                rt_d    = rf_q[rt_f];
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_d = alu_res;
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        pc_d      = br_taken ? br_target : npc_q;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        pc_d      = j_target;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                        rf_we     = (opcode == OP_JAL);
                        rf_waddr  = 5'd31;
                        rf_wdata  = npc_q;
                    end
                    OP_LW, OP_SW: begin
                        // A misaligned word access traps before any strobe is driven
                        state_d = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d      = rs_q;
                            retired_d = retired_q + CNT_W'(1);
                            state_d   = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.DM_ready) begin
                    if (is_sw) begin
                        pc_d      = npc_q;
                        retired_d = retired_q + CNT_W'(1);
                        state_d   = S_FETCH;
                    end else begin
                        mdr_d   = bus.ReadDataMem;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_waddr  = (opcode == OP_RTYPE) ? rd_f : rt_f;
                rf_wdata  = (opcode == OP_LW) ? mdr_q : alu_q;
                pc_d      = npc_q;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // FSM state and datapath registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            npc_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            npc_q     <= npc_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
        end
    end

    // Register file; $0 is never written so it always reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Strobes are a pure function of the MEM state, so they drop the cycle after DM_ready
    assign mem_active   = (state_q == S_MEM);
    assign is_sw        = (opcode == OP_SW);
    assign bus.IR_addr  = pc_q;
    assign bus.CEN      = !mem_active;
    assign bus.WEN      = !(mem_active && is_sw);
    assign bus.OEN      = !(mem_active && !is_sw);
    assign bus.A        = mem_active ? alu_q[DMEM_AW+1:2] : '0;
    assign bus.Data2Mem = (mem_active && is_sw) ? rt_q : 32'h0;
    assign halted       = (state_q == S_HALT);
    assign retired      = retired_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed programs against the multi-cycle core with a scoreboard.
// Retirements (count, next PC, cycles taken) and data accesses are queued as expectations
// and popped by a monitor that samples the bus on the falling edge.
module tb_mips_multicycle_core;
    localparam logic [31:0] HALT_OP = 32'hFC00_0000;

    typedef struct {
        logic [31:0] ret;
        logic [31:0] pc;
        int          gap;
    } ret_exp_t;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [31:0] data;
        int          len;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic [31:0] retired;

    mips_multicycle_core_if #(.DMEM_AW(7)) bus ();

    mips_multicycle_core #(.DMEM_AW(7), .CNT_W(32), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    ret_exp_t    ret_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] imem [64];
    logic [31:0] dmem [128];
    int          checks  = 0;
    int          errors  = 0;
    int          dm_wait = 0;
    int          ir_hold = 0;
    int          rcnt    = 0;
    int          dcnt    = 0;
    int          cyc     = 0;
    int          last    = 0;
    int          run_len = 0;
    logic [31:0] prev_ret = 32'h0;

    function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] it_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jt_i(input int op, input int addr);
        return {6'(op), 26'(addr >> 2)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ret(input int r, input int pc, input int gap);
        ret_exp_t e;
        e.ret = 32'(r); e.pc = 32'(pc); e.gap = gap;
        ret_q.push_back(e);
    endtask

    task automatic push_mem(input logic we, input int addr, input logic [31:0] data, input int len);
        mem_exp_t e;
        e.we = we; e.addr = 7'(addr); e.data = data; e.len = len;
        mem_q.push_back(e);
    endtask

    task automatic start_test(input int wait_dm, input int hold_ir);
        rst_n   = 1'b0;
        dm_wait = wait_dm;
        ir_hold = hold_ir;
        for (int i = 0; i < 64; i++)  imem[i] = HALT_OP;
        for (int i = 0; i < 128; i++) dmem[i] = 32'h0;
        ret_q.delete();
        mem_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic go();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic halt_chk(input string name, input int pc, input int ret);
        chk({name, "_halted"}, 32'(halted), 32'h1);
        chk({name, "_pc"}, bus.IR_addr, 32'(pc));
        chk({name, "_retired"}, retired, 32'(ret));
        chk({name, "_cen"}, 32'(bus.CEN), 32'h1);
    endtask

    task automatic end_test(input string name);
        chk({name, "_ret_left"}, 32'(ret_q.size()), 32'h0);
        chk({name, "_mem_left"}, 32'(mem_q.size()), 32'h0);
        ret_q.delete();
        mem_q.delete();
    endtask

    // Memory responders: fetch after an optional post-reset delay, data after dm_wait cycles
    initial begin
        bus.IR          = 32'h0;
        bus.IR_valid    = 1'b0;
        bus.DM_ready    = 1'b0;
        bus.ReadDataMem = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) rcnt = 0;
            else        rcnt++;
            bus.IR_valid = (rcnt >= ir_hold);
            bus.IR       = imem[bus.IR_addr[7:2]];
            if (bus.DM_ready) begin
                bus.DM_ready = 1'b0;
                dcnt = 0;
            end else if (bus.CEN) begin
                dcnt = 0;
            end else if (dcnt >= dm_wait) begin
                bus.DM_ready = 1'b1;
                if (!bus.WEN) dmem[bus.A] = bus.Data2Mem;
            end else begin
                dcnt++;
            end
            bus.ReadDataMem = dmem[bus.A];
        end
    end

    // Monitor: pops expectations on each retirement and on each strobed data cycle
    initial begin
        ret_exp_t re;
        mem_exp_t me;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cyc = 0; last = 0; prev_ret = 32'h0; run_len = 0;
            end else begin
                cyc++;
                if (retired !== prev_ret) begin
                    if (ret_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_retire: retired %0d pc %h", retired, bus.IR_addr);
                    end else begin
                        re = ret_q.pop_front();
                        chk("retired", retired, re.ret);
                        chk("next_pc", bus.IR_addr, re.pc);
                        chk("cycles", 32'(cyc - last), 32'(re.gap));
                    end
                    prev_ret = retired;
                    last = cyc;
                end
                if (!bus.CEN) begin
                    run_len++;
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe: A %h WEN %b OEN %b", bus.A, bus.WEN, bus.OEN);
                    end else begin
                        me = mem_q[0];
                        chk("mem_addr", 32'(bus.A), 32'(me.addr));
                        chk("mem_wen", 32'(bus.WEN), 32'(!me.we));
                        chk("mem_oen", 32'(bus.OEN), 32'(me.we));
                        if (me.we) chk("mem_wdata", bus.Data2Mem, me.data);
                        if (bus.DM_ready) begin
                            chk("mem_len", 32'(run_len), 32'(me.len));
                            void'(mem_q.pop_front());
                        end
                    end
                    if (bus.DM_ready) run_len = 0;
                end else begin
                    run_len = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int src [9] = '{3, 4, 5, 6, 7, 8, 9, 10, 0};
        logic [31:0] val [9] = '{32'h2, 32'h1, 32'h8, 32'h5, 32'hFFFF_FFFD,
                                 32'h50, 32'hF, 32'h0, 32'h0};
        int n;

        rst_n = 1'b0;
        #1;
        chk("rst_pc", bus.IR_addr, 32'h0);
        chk("rst_cen", 32'(bus.CEN), 32'h1);
        chk("rst_wen", 32'(bus.WEN), 32'h1);
        chk("rst_oen", 32'(bus.OEN), 32'h1);
        chk("rst_a", 32'(bus.A), 32'h0);
        chk("rst_d2m", bus.Data2Mem, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_retired", retired, 32'h0);

        // ALU program, results stored out through sw
        start_test(0, 0);
        imem[0]  = it_i('h08, 0, 1, 5);
        imem[1]  = it_i('h08, 0, 2, -3);
        imem[2]  = rt_i(1, 2, 3, 0, 'h20);
        imem[3]  = rt_i(2, 1, 4, 0, 'h2A);
        imem[4]  = rt_i(1, 2, 5, 0, 'h22);
        imem[5]  = rt_i(1, 2, 6, 0, 'h24);
        imem[6]  = rt_i(1, 2, 7, 0, 'h25);
        imem[7]  = rt_i(0, 1, 8, 4, 'h00);
        imem[8]  = rt_i(0, 2, 9, 28, 'h02);
        imem[9]  = rt_i(1, 2, 10, 0, 'h2A);
        imem[10] = it_i('h08, 0, 0, 7);
        for (int i = 0; i < 9; i++) begin
            imem[11 + i] = it_i('h2B, 0, src[i], 4 * i);
            push_mem(1'b1, i, val[i], 1);
        end
        for (int i = 0; i < 20; i++) push_ret(i + 1, 4 * (i + 1), 4);
        go();
        run(15);
        chk("alu_retired_at_15", retired, 32'd3);
        run(1);
        chk("alu_retired_at_16", retired, 32'd4);
        run(74);
        halt_chk("alu_end", 'h50, 20);
        end_test("alu");

        // sw/lw with 3 DM wait cycles, 2 fetch wait cycles, address aliasing
        start_test(3, 2);
        imem[0] = it_i('h08, 0, 1, 5);
        imem[1] = it_i('h2B, 0, 1, 'h104);
        imem[2] = it_i('h23, 0, 5, 'h104);
        imem[3] = it_i('h2B, 0, 5, 'h204);
        push_ret(1, 'h04, 6);
        push_ret(2, 'h08, 7);
        push_ret(3, 'h0C, 8);
        push_ret(4, 'h10, 7);
        push_mem(1'b1, 'h41, 32'h5, 4);
        push_mem(1'b0, 'h41, 32'h0, 4);
        push_mem(1'b1, 'h01, 32'h5, 4);
        go();
        run(35);
        halt_chk("mem_end", 'h10, 4);
        end_test("mem");

        // beq self-loop at 0x20
        start_test(0, 0);
        imem[0] = jt_i('h02, 'h20);
        imem[8] = it_i('h04, 1, 1, -1);
        push_ret(1, 'h20, 3);
        for (int k = 2; k <= 5; k++) push_ret(k, 'h20, 3);
        go();
        run(16);
        chk("loop_halted", 32'(halted), 32'h0);
        chk("loop_retired", retired, 32'd5);
        end_test("loop");

        // branch taken / not taken in both polarities
        start_test(0, 0);
        imem[0] = it_i('h08, 0, 1, 1);
        imem[1] = it_i('h05, 0, 0, 4);
        imem[2] = it_i('h04, 1, 0, 4);
        imem[3] = it_i('h05, 1, 0, 2);
        imem[6] = it_i('h04, 0, 0, -3);
        push_ret(1, 'h04, 4);
        push_ret(2, 'h08, 3);
        push_ret(3, 'h0C, 3);
        push_ret(4, 'h18, 3);
        push_ret(5, 'h10, 3);
        go();
        run(22);
        halt_chk("br_end", 'h10, 5);
        end_test("br");

        // jal then jr $31, link value stored out
        start_test(0, 0);
        imem[0]  = jt_i('h02, 'h10);
        imem[4]  = jt_i('h03, 'h40);
        imem[16] = it_i('h2B, 0, 31, 0);
        imem[17] = rt_i(31, 0, 0, 0, 'h08);
        push_ret(1, 'h10, 3);
        push_ret(2, 'h40, 3);
        push_ret(3, 'h44, 4);
        push_ret(4, 'h14, 3);
        push_mem(1'b1, 0, 32'h14, 1);
        go();
        run(20);
        halt_chk("jal_end", 'h14, 4);
        end_test("jal");

        // misaligned lw traps with no strobe
        start_test(0, 0);
        imem[0] = it_i('h23, 0, 5, 'h102);
        go();
        run(10);
        halt_chk("misalign", 0, 0);
        end_test("misalign");

        // unsupported opcode after one good instruction
        start_test(0, 0);
        imem[0] = it_i('h08, 0, 1, 1);
        push_ret(1, 'h04, 4);
        go();
        run(10);
        halt_chk("badop", 4, 1);
        end_test("badop");

        // unsupported funct
        start_test(0, 0);
        imem[0] = rt_i(1, 2, 3, 0, 'h21);
        go();
        run(8);
        halt_chk("badfn", 0, 0);
        end_test("badfn");

        // reset while sw waits for DM_ready
        start_test(20, 0);
        imem[0] = it_i('h08, 0, 1, 5);
        imem[1] = it_i('h2B, 0, 1, 'h10);
        push_ret(1, 'h04, 4);
        push_mem(1'b1, 4, 32'h5, 99);
        go();
        n = 0;
        while (bus.CEN && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rstmem_reached", 32'(bus.CEN), 32'h0);
        run(2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmem_cen", 32'(bus.CEN), 32'h1);
        chk("rstmem_wen", 32'(bus.WEN), 32'h1);
        chk("rstmem_oen", 32'(bus.OEN), 32'h1);
        chk("rstmem_a", 32'(bus.A), 32'h0);
        chk("rstmem_d2m", bus.Data2Mem, 32'h0);
        chk("rstmem_pc", bus.IR_addr, 32'h0);
        chk("rstmem_retired", retired, 32'h0);
        mem_q.delete();
        end_test("rstmem");

        // after reset, $1 is back to zero
        start_test(0, 0);
        imem[0] = it_i('h2B, 0, 1, 0);
        push_ret(1, 'h04, 4);
        push_mem(1'b1, 0, 32'h0, 1);
        go();
        run(8);
        halt_chk("post_rst", 4, 1);
        end_test("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Executes the same subset of the instruction set through a state machine, with one instruction in flight at a time.
- Handshakes with instruction memory and data memory, so both can take any number of wait states.
- Adds a configurable data-address width, an exception halt, and a retired-instruction counter.

Parameters:
- DMEM_AW, 7, data memory word-address width; A = ALU result [DMEM_AW+1:2].
- CNT_W, 32, width of the retired-instruction counter.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IR_addr  out  32  instruction fetch address (the PC).
- IR  in  32  instruction word.
- IR_valid  in  1  IR is valid for the current IR_addr.
- ReadDataMem  in  32  data memory read data.
- DM_ready  in  1  data memory has completed the current access.
- CEN  out  1  data memory chip enable, active-low.
- WEN  out  1  data memory write enable, active-low.
- OEN  out  1  data memory output enable, active-low.
- A  out  DMEM_AW  data memory word address.
- Data2Mem  out  32  data memory write data (rt).
- halted  out  1  core has stopped on an exception.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = FETCH; PC = RESET_PC.
  - All 32 registers = 0.
  - CEN = WEN = OEN = 1; A = 0; Data2Mem = 0.
  - halted = 0; retired = 0.
  - Reset asserted in any state (including MEM mid-handshake) aborts the instruction with no register or PC update.
- Supported instructions:
  - R-type: add, sub, and, or, slt, sll, srl, jr.
  - I-type: addi, lw, sw, beq, bne.
  - J-type: j, jal.
- Arithmetic and register file rules:
  - add/sub/addi wrap modulo 2^32; no overflow trap.
  - slt is a signed compare.
  - sll/srl shift by the shamt field, IR[10:6].
  - Register $0 reads as 0 and ignores writes.
- FETCH:
  - IR_addr = PC.
  - Wait while IR_valid = 0.
  - On a cycle with IR_valid = 1: latch IR into the instruction register, latch PC+4 into NPC, go to DECODE.
- DECODE (1 cycle):
  - Read rs and rt into operand registers; sign-extend imm16.
  - Unsupported opcode or funct: go to HALT.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - Compute the ALU result into ALUOut.
  - beq/bne: PC = taken ? NPC + (sext(imm) << 2) : NPC; retired += 1; go to FETCH.
  - j: PC = {NPC[31:28], IR[25:0], 2'b00}; retired += 1; go to FETCH.
  - jal: same PC update as j, plus $31 = NPC; retired += 1; go to FETCH.
  - jr: PC = rs; retired += 1; go to FETCH.
  - lw/sw: if ALUOut[1:0] != 0, go to HALT and drive no memory strobe; otherwise go to MEM.
  - R-type and addi: go to WB.
- MEM (lw/sw):
  - Drive CEN = 0.
  - lw: OEN = 0, WEN = 1.
  - sw: WEN = 0, OEN = 1, Data2Mem = rt.
  - A = ALUOut[DMEM_AW+1:2]; upper address bits are ignored, so addresses alias modulo 2^(DMEM_AW+2).
  - A, Data2Mem and the strobes are held stable until a cycle with DM_ready = 1.
  - On that cycle: lw latches ReadDataMem into MDR and goes to WB; sw sets PC = NPC, retired += 1, and goes to FETCH.
  - The strobes return to 1 on the next cycle.
- WB (1 cycle):
  - Write the destination register: rd for R-type, rt for addi and lw (lw writes MDR).
  - PC = NPC; retired += 1; go to FETCH.
- HALT:
  - halted = 1; all memory strobes stay inactive.
  - PC holds the address of the faulting instruction; retired is frozen.
  - Only reset leaves HALT.
- Latency with zero wait states (cycles per instruction):
  - beq, bne, j, jal, jr: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
  - Each wait cycle on IR_valid or DM_ready adds one cycle.
- retired wraps modulo 2^CNT_W.
- IR_valid and DM_ready are ignored outside FETCH and MEM respectively.

Test Plan:
- Zero-wait program:
  - Stimulus: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1.
  - Response: $3 = 2, $4 = 1, retired = 4 after 16 cycles.
- sw then lw, DMEM_AW = 7, DM_ready delayed 3 cycles:
  - Stimulus: sw $1,0x104($0), then lw $5,0x104($0).
  - Response: A = 7'h41 held stable with CEN = 0 for 4 cycles on each access; $5 = 5; retired increments once per instruction.
- Branches:
  - Stimulus: beq $1,$1,-1 at PC 0x20; then bne $0,$0,+4.
  - Response: beq gives next PC 0x20 (self-loop); bne falls through to PC+4.
- jal then jr $31:
  - Stimulus: jal at PC 0x10 targeting 0x40; then jr $31.
  - Response: $31 = 0x14, PC sequence 0x40 then 0x14.
- Exceptions:
  - Stimulus: lw with address 0x102; separately, opcode 6'h3F.
  - Response: halted = 1, no CEN pulse, PC and retired frozen.
- Reset mid-MEM:
  - Stimulus: assert rst_n = 0 while sw waits for DM_ready.
  - Response: strobes go to 1 immediately, PC = 0, no register written.
